rf_arbiter_2ch: RTL and testbench
=================================

Name: rf_arbiter_2ch

Overview:
- Shares one parameterized register file between two client ports.
- Performs one access (read or write) per clock cycle.
- Picks the winner each cycle by round-robin, with an optional lock that gives one client a bounded burst of consecutive grants.
- Sits between two requesting datapaths (e.g. a processor bus slave and a DMA-style engine) and the register-file storage.

Parameters:
- DATA_WIDTH, 8, bits per register.
- ADDR_WIDTH, 2, address bits; the file holds 2**ADDR_WIDTH registers.
- MAX_BURST, 4, maximum consecutive locked grants to one client while the other client is requesting; must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- reset_n  in  1  synchronous, active-low reset.
- req0, req1  in  1 each  client access request; held until granted.
- lock0, lock1  in  1 each  client asks to keep ownership for following accesses.
- wr0, wr1  in  1 each  1 = write, 0 = read.
- addr0, addr1  in  ADDR_WIDTH each  register address.
- wdata0, wdata1  in  DATA_WIDTH each  write data.
- gnt0, gnt1  out  1 each  access accepted this cycle (combinational).
- rvalid0, rvalid1  out  1 each  read data valid; one-cycle pulse.
- rdata0, rdata1  out  DATA_WIDTH each  registered read data.

Behaviour:
- Reset (sampled on clk edge with reset_n=0):
  - state=IDLE, burst_cnt=0, last=1 (so client 0 wins the first tie).
  - rvalid0/1=0, rdata0/1=0.
  - While reset_n=0, gnt0/1 are forced to 0 and no write occurs.
  - Register contents are not reset.
- State: FSM with IDLE, OWN0, OWN1; burst_cnt of width clog2(MAX_BURST+1); last = index of the most recently granted client.
- Winner selection (combinational, every cycle):
  - If state=OWNk and req_k and lock_k and (burst_cnt<MAX_BURST or other client not requesting), winner=k.
  - Else if both clients request, winner = client != last.
  - Else the single requester wins.
  - Else no winner.
- gnt_k = (winner==k); at most one grant per cycle; no other latency.
- Granted access executes at the closing clock edge:
  - Write: rf[addr_k] <= wdata_k.
  - Read: rdata_k <= rf[addr_k] and rvalid_k=1 for exactly the next cycle.
  - rdata_k holds its value until the next granted read by client k.
  - A granted write never pulses rvalid.
- Next state on a grant to k:
  - last<=k.
  - If lock_k: state<=OWNk; burst_cnt <= (state==OWNk) ? min(burst_cnt+1, MAX_BURST) : 1. The counter saturates.
  - Else: state<=IDLE, burst_cnt<=0.
- No grant: state<=IDLE, burst_cnt<=0.
- Burst cap: an owner locked against a requesting other client gets exactly MAX_BURST consecutive grants. The other client then wins one cycle (last=owner) and ownership is lost.
- Dropping lock or req ends ownership immediately per the rules above.
- Read-after-write: a write at edge N is visible to any read granted in the cycle after edge N. The same-cycle case cannot occur (single access per cycle).
- Grant depends only on req/lock/state; wr/addr/wdata do not affect arbitration.
- Reset mid-burst: the next cycle is IDLE with last=1, any pending rvalid is cleared, and there are no partial writes.

Decomposition:
- Package rf_arb_pkg:
  - state_t enum {IDLE, OWN0, OWN1}.
  - client_t (1-bit client index).
- Sub-module reg_file: parameterized DATA_WIDTH/ADDR_WIDTH, one write port (clk, wr_en, w_addr, w_data), asynchronous read (r_addr, r_data), no reset.
- The arbiter muxes the winner's wr/addr/wdata into reg_file; wr_en = gnt & wr.

Test Plan:
- Post-reset, c0 writes addr2=0xA5, then reads addr2 -> gnt0 in the request cycle each time; rvalid0 pulses 1 cycle after the read grant with rdata0=0xA5; rvalid1 stays 0.
- req0 and req1 held high, no lock, from reset -> grants alternate 0,1,0,1... starting with client 0; never both high.
- c0 holds req0/lock0, c1 holds req1 -> gnt0 for 4 cycles, gnt1 for 1 cycle, then gnt0 for 4 cycles, etc. (MAX_BURST=4).
- c0 locked, req1=0 for 10 cycles -> gnt0 every cycle and burst_cnt saturates at 4. Then req1 rises -> gnt1 on the next cycle.
- c0 writes addr1=0x3C in cycle N, c1 reads addr1 in cycle N+1 -> rvalid1 in N+2 with rdata1=0x3C.
- reset_n low for 1 cycle during c0's 2nd locked grant with a read pending -> gnt0/gnt1=0 during reset, rvalid cleared; with both requesting afterward, the first grant goes to c0 (last=1) and a new burst count starts at 1.

Source files
------------

// File: rtl/rf_arb_pkg.sv
// ============================================================================
// Module : rf_arb_pkg
// Brief  : Shared types for the two-client register-file arbiter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rf_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    typedef logic client_t;

    localparam client_t c_CLIENT0 = 1'b0;
    localparam client_t c_CLIENT1 = 1'b1;

    function automatic state_t own_state(input client_t c);
        return (c == c_CLIENT1) ? OWN1 : OWN0;
    endfunction

endpackage

`default_nettype wire

// File: rtl/reg_file.sv
// ============================================================================
// Module : reg_file
// Brief  : Single write port, asynchronous read register file (no reset).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module reg_file #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] w_addr,
    input  logic [DATA_WIDTH-1:0] w_data,
    input  logic [ADDR_WIDTH-1:0] r_addr,
    output logic [DATA_WIDTH-1:0] r_data
);

    logic [DATA_WIDTH-1:0] r_mem [0:(2**ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[w_addr] <= w_data;
        end
    end

    assign r_data = r_mem[r_addr];

endmodule

`default_nettype wire

// File: rtl/rf_arbiter_2ch.sv
// ============================================================================
// Module : rf_arbiter_2ch
// Brief  : Round-robin arbiter with bounded lock bursts sharing one reg file.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rf_arbiter_2ch
    import rf_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 2,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic                  req1,
    input  logic                  lock0,
    input  logic                  lock1,
    input  logic                  wr0,
    input  logic                  wr1,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [ADDR_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0] wdata0,
    input  logic [DATA_WIDTH-1:0] wdata1,
    output logic                  gnt0,
    output logic                  gnt1,
    output logic                  rvalid0,
    output logic                  rvalid1,
    output logic [DATA_WIDTH-1:0] rdata0,
    output logic [DATA_WIDTH-1:0] rdata1
);

    localparam int                 c_CNT_W   = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_W-1:0] c_MAX_CNT = c_CNT_W'(MAX_BURST);
    localparam logic [c_CNT_W-1:0] c_ONE     = c_CNT_W'(1);

    state_t                r_state, w_state_nxt;
    logic [c_CNT_W-1:0]    r_burst_cnt, w_burst_nxt;
    client_t               r_last, w_last_nxt;
    client_t               w_winner;
    logic                  w_gnt_valid;
    logic                  w_hold0, w_hold1;
    logic                  w_sel_wr, w_sel_lock, w_wr_en;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata, w_rd_data;
    logic                  r_rvalid0, r_rvalid1;
    logic [DATA_WIDTH-1:0] r_rdata0, r_rdata1;

    // A locked owner keeps the port until its burst cap, unless nobody else wants it.
    assign w_hold0 = (r_state == OWN0) && req0 && lock0 && ((r_burst_cnt < c_MAX_CNT) || !req1);
    assign w_hold1 = (r_state == OWN1) && req1 && lock1 && ((r_burst_cnt < c_MAX_CNT) || !req0);

    always_comb begin
        w_gnt_valid = 1'b0;
        w_winner    = c_CLIENT0;
        if (!reset_n) begin
            w_gnt_valid = 1'b0;
        end else if (w_hold0) begin
            w_gnt_valid = 1'b1;
            w_winner    = c_CLIENT0;
        end else if (w_hold1) begin
            w_gnt_valid = 1'b1;
            w_winner    = c_CLIENT1;
        end else if (req0 && req1) begin
            w_gnt_valid = 1'b1;
            w_winner    = ~r_last;
        end else if (req0) begin
            w_gnt_valid = 1'b1;
            w_winner    = c_CLIENT0;
        end else if (req1) begin
            w_gnt_valid = 1'b1;
            w_winner    = c_CLIENT1;
        end
    end

    assign gnt0 = w_gnt_valid && (w_winner == c_CLIENT0);
    assign gnt1 = w_gnt_valid && (w_winner == c_CLIENT1);

    assign w_sel_wr    = (w_winner == c_CLIENT1) ? wr1    : wr0;
    assign w_sel_lock  = (w_winner == c_CLIENT1) ? lock1  : lock0;
    assign w_sel_addr  = (w_winner == c_CLIENT1) ? addr1  : addr0;
    assign w_sel_wdata = (w_winner == c_CLIENT1) ? wdata1 : wdata0;
    assign w_wr_en     = w_gnt_valid && w_sel_wr;

    reg_file #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_reg_file (
        .clk    (clk),
        .wr_en  (w_wr_en),
        .w_addr (w_sel_addr),
        .w_data (w_sel_wdata),
        .r_addr (w_sel_addr),
        .r_data (w_rd_data)
    );

    always_comb begin
        w_state_nxt = IDLE;
        w_burst_nxt = '0;
        w_last_nxt  = r_last;
        if (w_gnt_valid) begin
            w_last_nxt = w_winner;
            if (w_sel_lock) begin
                w_state_nxt = own_state(w_winner);
                if (r_state == own_state(w_winner)) begin
                    w_burst_nxt = (r_burst_cnt < c_MAX_CNT) ? (r_burst_cnt + c_ONE) : r_burst_cnt;
                end else begin
                    w_burst_nxt = c_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_burst_cnt <= '0;
            r_last      <= c_CLIENT1;
            r_rvalid0   <= 1'b0;
            r_rvalid1   <= 1'b0;
            r_rdata0    <= '0;
            r_rdata1    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_burst_cnt <= w_burst_nxt;
            r_last      <= w_last_nxt;
            r_rvalid0   <= gnt0 && !wr0;
            r_rvalid1   <= gnt1 && !wr1;
            if (gnt0 && !wr0) begin
                r_rdata0 <= w_rd_data;
            end
            if (gnt1 && !wr1) begin
                r_rdata1 <= w_rd_data;
            end
        end
    end

    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rdata0  = r_rdata0;
    assign rdata1  = r_rdata1;

endmodule

`default_nettype wire

// File: tb/tb_rf_arbiter_2ch.sv
// ============================================================================
// Module : tb_rf_arbiter_2ch
// Brief  : Randomized self-checking bench against a behavioural arbiter model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_rf_arbiter_2ch;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          req0, req1, lock0, lock1, wr0, wr1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: owner = -1 when nobody holds a lock.
    int          m_owner, m_cnt, m_last;
    logic [DW-1:0] m_rf [4];
    bit          m_known [4];
    bit          m_rvalid [2];
    logic [DW-1:0] m_rdata [2];
    bit          m_rd_known [2];

    always #5 clk = ~clk;

    rf_arbiter_2ch #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .MAX_BURST  (MB)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .req0    (req0),
        .req1    (req1),
        .lock0   (lock0),
        .lock1   (lock1),
        .wr0     (wr0),
        .wr1     (wr1),
        .addr0   (addr0),
        .addr1   (addr1),
        .wdata0  (wdata0),
        .wdata1  (wdata1),
        .gnt0    (gnt0),
        .gnt1    (gnt1),
        .rvalid0 (rvalid0),
        .rvalid1 (rvalid1),
        .rdata0  (rdata0),
        .rdata1  (rdata1)
    );

    function automatic int model_win();
        bit r [2];
        bit l [2];
        r[0] = req0; r[1] = req1; l[0] = lock0; l[1] = lock1;
        if (!reset_n) return -1;
        for (int k = 0; k < 2; k++)
            if (m_owner == k && r[k] && l[k] && (m_cnt < MB || !r[1-k])) return k;
        if (r[0] && r[1]) return 1 - m_last;
        if (r[0]) return 0;
        if (r[1]) return 1;
        return -1;
    endfunction

    task automatic model_edge();
        int w;
        bit wr_k, lk_k;
        int a_k;
        w = model_win();
        if (!reset_n) begin
            m_owner = -1; m_cnt = 0; m_last = 1;
            for (int k = 0; k < 2; k++) begin
                m_rvalid[k] = 0; m_rdata[k] = '0; m_rd_known[k] = 1;
            end
            return;
        end
        m_rvalid[0] = 0; m_rvalid[1] = 0;
        if (w < 0) begin
            m_owner = -1; m_cnt = 0;
            return;
        end
        wr_k = (w == 0) ? wr0 : wr1;
        lk_k = (w == 0) ? lock0 : lock1;
        a_k  = (w == 0) ? int'(addr0) : int'(addr1);
        if (wr_k) begin
            m_rf[a_k] = (w == 0) ? wdata0 : wdata1;
            m_known[a_k] = 1;
        end else begin
            m_rvalid[w] = 1; m_rdata[w] = m_rf[a_k]; m_rd_known[w] = m_known[a_k];
        end
        m_last = w;
        if (lk_k) begin
            m_cnt = (m_owner == w) ? ((m_cnt + 1 > MB) ? MB : m_cnt + 1) : 1;
            m_owner = w;
        end else begin
            m_owner = -1; m_cnt = 0;
        end
    endtask

    task automatic drive(bit r0, bit l0, bit w0, int a0, int d0,
                         bit r1, bit l1, bit w1, int a1, int d1);
        req0 = r0; lock0 = l0; wr0 = w0; addr0 = AW'(a0); wdata0 = DW'(d0);
        req1 = r1; lock1 = l1; wr1 = w1; addr1 = AW'(a1); wdata1 = DW'(d1);
    endtask

    task automatic advance();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        advance();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        drive(1, 1, 1, 0, 8'h11, 1, 1, 1, 1, 8'h22);
        @(negedge clk);
        checks += 2;
        if (gnt0 !== 1'b0) begin failures++; $display("FAIL reset_gnt0 got=%b exp=0", gnt0); end
        if (gnt1 !== 1'b0) begin failures++; $display("FAIL reset_gnt1 got=%b exp=0", gnt1); end
        advance();
        reset_n = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 4;
        if (rvalid0 !== 1'b0) begin failures++; $display("FAIL reset_rvalid0 got=%b exp=0", rvalid0); end
        if (rvalid1 !== 1'b0) begin failures++; $display("FAIL reset_rvalid1 got=%b exp=0", rvalid1); end
        if (rdata0 !== '0) begin failures++; $display("FAIL reset_rdata0 got=%h exp=00", rdata0); end
        if (rdata1 !== '0) begin failures++; $display("FAIL reset_rdata1 got=%h exp=00", rdata1); end
        advance();
    endtask

    task automatic test_write_read();
        drive(1, 0, 1, 2, 8'hA5, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 2;
        if (gnt0 !== 1'b1) begin failures++; $display("FAIL wr_gnt0 got=%b exp=1", gnt0); end
        if (gnt1 !== 1'b0) begin failures++; $display("FAIL wr_gnt1 got=%b exp=0", gnt1); end
        advance();
        drive(1, 0, 0, 2, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 2;
        if (gnt0 !== 1'b1) begin failures++; $display("FAIL rd_gnt0 got=%b exp=1", gnt0); end
        if (rvalid0 !== 1'b0) begin failures++; $display("FAIL wr_no_rvalid got=%b exp=0", rvalid0); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 3;
        if (rvalid0 !== 1'b1) begin failures++; $display("FAIL rd_rvalid0 got=%b exp=1", rvalid0); end
        if (rdata0 !== 8'hA5) begin failures++; $display("FAIL rd_rdata0 got=%h exp=a5", rdata0); end
        if (rvalid1 !== 1'b0) begin failures++; $display("FAIL rd_rvalid1 got=%b exp=0", rvalid1); end
        advance();
        @(negedge clk);
        checks += 2;
        if (rvalid0 !== 1'b0) begin failures++; $display("FAIL rvalid_pulse got=%b exp=0", rvalid0); end
        if (rdata0 !== 8'hA5) begin failures++; $display("FAIL rdata_hold got=%h exp=a5", rdata0); end
        advance();
    endtask

    task automatic test_round_robin();
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(1, 0, 1'($urandom), $urandom_range(3), $urandom,
                  1, 0, 1'($urandom), $urandom_range(3), $urandom);
            @(negedge clk);
            checks += 4;
            if (gnt0 !== (i % 2 == 0)) begin failures++; $display("FAIL rr_gnt0[%0d] got=%b exp=%b", i, gnt0, i % 2 == 0); end
            if (gnt1 !== (i % 2 == 1)) begin failures++; $display("FAIL rr_gnt1[%0d] got=%b exp=%b", i, gnt1, i % 2 == 1); end
            if (rvalid0 !== m_rvalid[0]) begin failures++; $display("FAIL rr_rvalid0[%0d] got=%b exp=%b", i, rvalid0, m_rvalid[0]); end
            if (rvalid1 !== m_rvalid[1]) begin failures++; $display("FAIL rr_rvalid1[%0d] got=%b exp=%b", i, rvalid1, m_rvalid[1]); end
            advance();
        end
    endtask

    task automatic test_burst_cap();
        do_reset();
        for (int i = 0; i < 15; i++) begin
            drive(1, 1, 1, $urandom_range(3), $urandom, 1, 0, 1, $urandom_range(3), $urandom);
            @(negedge clk);
            checks += 2;
            if (gnt0 !== (i % 5 != 4)) begin failures++; $display("FAIL burst_gnt0[%0d] got=%b exp=%b", i, gnt0, i % 5 != 4); end
            if (gnt1 !== (i % 5 == 4)) begin failures++; $display("FAIL burst_gnt1[%0d] got=%b exp=%b", i, gnt1, i % 5 == 4); end
            advance();
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, 1, 1, i % 4, i, 0, 0, 0, 0, 0);
            @(negedge clk);
            checks++;
            if (gnt0 !== 1'b1) begin failures++; $display("FAIL sat_gnt0[%0d] got=%b exp=1", i, gnt0); end
            advance();
        end
        drive(1, 1, 1, 0, 0, 1, 0, 1, 3, 8'h77);
        @(negedge clk);
        checks += 2;
        if (gnt1 !== 1'b1) begin failures++; $display("FAIL sat_gnt1 got=%b exp=1", gnt1); end
        if (gnt0 !== 1'b0) begin failures++; $display("FAIL sat_gnt0_yield got=%b exp=0", gnt0); end
        advance();
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin failures++; $display("FAIL sat_regain got=%b exp=1", gnt0); end
        advance();
    endtask

    task automatic test_raw_cross();
        do_reset();
        drive(1, 0, 1, 1, 8'h3C, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin failures++; $display("FAIL raw_wr_gnt0 got=%b exp=1", gnt0); end
        advance();
        drive(0, 0, 0, 0, 0, 1, 0, 0, 1, 0);
        @(negedge clk);
        checks++;
        if (gnt1 !== 1'b1) begin failures++; $display("FAIL raw_rd_gnt1 got=%b exp=1", gnt1); end
        advance();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        checks += 2;
        if (rvalid1 !== 1'b1) begin failures++; $display("FAIL raw_rvalid1 got=%b exp=1", rvalid1); end
        if (rdata1 !== 8'h3C) begin failures++; $display("FAIL raw_rdata1 got=%h exp=3c", rdata1); end
        advance();
    endtask

    task automatic test_reset_midburst();
        do_reset();
        drive(1, 1, 0, 2, 0, 1, 0, 0, 0, 0);
        @(negedge clk);
        checks++;
        if (gnt0 !== 1'b1) begin failures++; $display("FAIL mid_first_gnt0 got=%b exp=1", gnt0); end
        advance();
        reset_n = 1'b0;
        @(negedge clk);
        checks += 3;
        if (gnt0 !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt0 got=%b exp=0", gnt0); end
        if (gnt1 !== 1'b0) begin failures++; $display("FAIL mid_rst_gnt1 got=%b exp=0", gnt1); end
        if (rvalid0 !== 1'b1) begin failures++; $display("FAIL mid_pending_rvalid got=%b exp=1", rvalid0); end
        advance();
        reset_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks += 2;
            if (i == 0 && rvalid0 !== 1'b0) begin failures++; $display("FAIL mid_rvalid_cleared got=%b exp=0", rvalid0); end
            if (gnt0 !== (i < 4)) begin failures++; $display("FAIL mid_gnt0[%0d] got=%b exp=%b", i, gnt0, i < 4); end
            advance();
        end
    endtask

    task automatic test_random();
        int w;
        do_reset();
        for (int a = 0; a < 4; a++) begin
            drive(1, 0, 1, a, $urandom, 0, 0, 0, 0, 0);
            advance();
        end
        for (int i = 0; i < 300; i++) begin
            reset_n = ($urandom_range(39) != 0);
            drive(($urandom_range(3) != 0), ($urandom_range(2) != 0), 1'($urandom), $urandom_range(3), $urandom,
                  ($urandom_range(3) != 0), ($urandom_range(2) != 0), 1'($urandom), $urandom_range(3), $urandom);
            @(negedge clk);
            w = model_win();
            checks += 6;
            if (gnt0 !== (w == 0)) begin failures++; $display("FAIL rnd_gnt0[%0d] got=%b exp=%b", i, gnt0, w == 0); end
            if (gnt1 !== (w == 1)) begin failures++; $display("FAIL rnd_gnt1[%0d] got=%b exp=%b", i, gnt1, w == 1); end
            if (rvalid0 !== m_rvalid[0]) begin failures++; $display("FAIL rnd_rvalid0[%0d] got=%b exp=%b", i, rvalid0, m_rvalid[0]); end
            if (rvalid1 !== m_rvalid[1]) begin failures++; $display("FAIL rnd_rvalid1[%0d] got=%b exp=%b", i, rvalid1, m_rvalid[1]); end
            if (m_rd_known[0] && rdata0 !== m_rdata[0]) begin failures++; $display("FAIL rnd_rdata0[%0d] got=%h exp=%h", i, rdata0, m_rdata[0]); end
            if (m_rd_known[1] && rdata1 !== m_rdata[1]) begin failures++; $display("FAIL rnd_rdata1[%0d] got=%h exp=%h", i, rdata1, m_rdata[1]); end
            advance();
        end
        reset_n = 1'b1;
    endtask

    initial begin
        m_owner = -1; m_cnt = 0; m_last = 1;
        for (int a = 0; a < 4; a++) begin m_known[a] = 0; m_rf[a] = '0; end
        for (int k = 0; k < 2; k++) begin m_rvalid[k] = 0; m_rdata[k] = '0; m_rd_known[k] = 0; end
        reset_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #1;
        test_reset();
        test_write_read();
        test_round_robin();
        test_burst_cap();
        test_saturate();
        test_raw_cross();
        test_reset_midburst();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
